// File: rtl/msx_host_pkg.sv
// msx_host_pkg: shared command layout, FSM encoding and response constants for the host queue.
package msx_host_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic        mio;
    logic        slot;
  } cmd_t;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t RESP  = 2'd2;
  localparam state_t GAP   = 2'd3;
  localparam logic [7:0] RSP_TIMEOUT_DATA = 8'hFF;
endpackage

// File: rtl/msx_cmd_fifo.sv
// msx_cmd_fifo: synchronous command FIFO with wrap-bit pointers; full blocks pushes even during a pop.
module msx_cmd_fifo
  import msx_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     din,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic wr, rd;
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  assign level = wptr - rptr;
  assign full = level == (AW + 1)'(DEPTH);
  assign empty = wptr == rptr;
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge CLK)
    if (wr) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/msx_host_cmd_queue.sv
// msx_host_cmd_queue: buffers host transactions and issues them one at a time to the MSX bus
// cycle engine, returning read data and aborting cycles that exceed TIMEOUT.
module msx_host_cmd_queue
  import msx_host_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   HOST_VALID,
  output logic                   HOST_READY,
  input  logic [15:0]            HOST_ADDR,
  input  logic [7:0]             HOST_WDATA,
  input  logic                   HOST_RW,
  input  logic                   HOST_MIO,
  input  logic                   HOST_SLOT,
  output logic                   RSP_VALID,
  output logic [7:0]             RSP_DATA,
  input  logic                   RSP_READY,
  output logic                   BUS_EN,
  output logic [15:0]            BUS_ADDR,
  output logic [7:0]             BUS_WDATA,
  output logic                   BUS_RW,
  output logic                   BUS_MIO,
  output logic                   BUS_SLOT,
  input  logic                   BUS_DONE,
  input  logic [7:0]             BUS_RDATA,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   ERR,
  input  logic                   CLR_ERR
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  state_t state;
  cmd_t head, host_cmd;
  logic full, empty, expire;
  logic [TW-1:0] timer;
  assign host_cmd = {HOST_ADDR, HOST_WDATA, HOST_RW, HOST_MIO, HOST_SLOT};
  assign HOST_READY = ~full;
  assign expire = timer == TLAST;
  msx_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (HOST_VALID),
    .pop   (state == IDLE),
    .din   (host_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );
  // ERR clear is written first so a same-cycle timeout set overrides it.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state     <= IDLE;
      timer     <= '0;
      BUS_EN    <= 1'b0;
      BUS_ADDR  <= '0;
      BUS_WDATA <= '0;
      BUS_RW    <= 1'b0;
      BUS_MIO   <= 1'b0;
      BUS_SLOT  <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      ERR       <= 1'b0;
    end else begin
      if (CLR_ERR) ERR <= 1'b0;
      case (state)
        IDLE:
          if (!empty) begin
            {BUS_ADDR, BUS_WDATA, BUS_RW, BUS_MIO, BUS_SLOT} <= head;
            BUS_EN <= 1'b1;
            timer  <= '0;
            state  <= ISSUE;
          end
        ISSUE:
          if (BUS_DONE || expire) begin
            BUS_EN    <= 1'b0;
            RSP_VALID <= ~BUS_RW;
            state     <= BUS_RW ? GAP : RESP;
            if (!BUS_DONE) ERR <= 1'b1;
            if (!BUS_RW) RSP_DATA <= BUS_DONE ? BUS_RDATA : RSP_TIMEOUT_DATA;
          end else timer <= timer + 1'b1;
        RESP:
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= GAP;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_msx_host_cmd_queue.sv
// tb_msx_host_cmd_queue: directed stimulus with scoreboard monitors for issued bus commands and read responses.
module tb_msx_host_cmd_queue;
  import msx_host_pkg::*;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  logic CLK = 1'b0, RST;
  logic HOST_VALID, HOST_READY, HOST_RW, HOST_MIO, HOST_SLOT;
  logic [15:0] HOST_ADDR, BUS_ADDR;
  logic [7:0] HOST_WDATA, RSP_DATA, BUS_WDATA, BUS_RDATA;
  logic RSP_VALID, RSP_READY, BUS_EN, BUS_RW, BUS_MIO, BUS_SLOT, BUS_DONE, ERR, CLR_ERR;
  logic [$clog2(DEPTH):0] LEVEL;
  int checks = 0, errors = 0, bus_rises = 0, eng_delay = 0;
  logic [7:0] eng_rdata = 8'h00;
  cmd_t exp_bus[$];
  logic [7:0] exp_rsp[$];

  msx_host_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .HOST_VALID(HOST_VALID), .HOST_READY(HOST_READY),
    .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA), .HOST_RW(HOST_RW), .HOST_MIO(HOST_MIO),
    .HOST_SLOT(HOST_SLOT), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_READY(RSP_READY),
    .BUS_EN(BUS_EN), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_RW(BUS_RW),
    .BUS_MIO(BUS_MIO), .BUS_SLOT(BUS_SLOT), .BUS_DONE(BUS_DONE), .BUS_RDATA(BUS_RDATA),
    .LEVEL(LEVEL), .ERR(ERR), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired before the required event", name);
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting edge with HOST_VALID still high.
  task automatic push(logic [15:0] a, logic [7:0] d, logic rw, logic mio, logic slot, logic [7:0] ersp);
    int n = 0;
    HOST_VALID = 1'b1; HOST_ADDR = a; HOST_WDATA = d; HOST_RW = rw; HOST_MIO = mio; HOST_SLOT = slot;
    while (!HOST_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) fail("push_ready");
    else begin
      exp_bus.push_back({a, d, rw, mio, slot});
      if (!rw) exp_rsp.push_back(ersp);
      @(negedge CLK);
    end
  endtask

  task automatic wait_en(logic v, string name);
    int n = 0;
    while (BUS_EN !== v && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n == 100) fail(name);
  endtask

  task automatic count_en(output int n);
    n = 0;
    while (BUS_EN && n < 100) begin
      @(negedge CLK);
      n++;
    end
  endtask

  // Bus cycle engine model: DONE after eng_delay cycles of BUS_EN; 0 means never.
  initial begin
    int cnt;
    bit sent;
    cnt = 0; sent = 0; BUS_DONE = 1'b0; BUS_RDATA = 8'h00;
    forever begin
      @(negedge CLK);
      BUS_DONE = 1'b0;
      if (!BUS_EN) begin
        cnt = 0;
        sent = 0;
      end else if (!sent) begin
        cnt++;
        if (cnt == eng_delay) begin
          BUS_DONE = 1'b1;
          BUS_RDATA = eng_rdata;
          sent = 1;
        end
      end
    end
  end

  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (BUS_EN && !prev) begin
        bus_rises++;
        if (exp_bus.size() == 0) chk("bus_unexpected_issue", 32'(BUS_ADDR), 32'hFFFFFFFF);
        else begin
          cmd_t e;
          e = exp_bus.pop_front();
          chk("bus_cmd", 32'({BUS_ADDR, BUS_WDATA, BUS_RW, BUS_MIO, BUS_SLOT}), 32'(e));
        end
      end
      prev = BUS_EN;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (RSP_VALID && RSP_READY) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(RSP_DATA), 32'hFFFFFFFF);
        else chk("rsp_data", 32'(RSP_DATA), 32'(exp_rsp.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b0; HOST_VALID = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0; HOST_RW = 1'b0;
    HOST_MIO = 1'b0; HOST_SLOT = 1'b0; RSP_READY = 1'b1; CLR_ERR = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_bus_en", 32'(BUS_EN), 0);
    chk("rst_host_ready", 32'(HOST_READY), 1);
    chk("rst_level", 32'(LEVEL), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_err", 32'(ERR), 0);
    RST = 1'b1;
    @(negedge CLK);

    // single read, DONE after 6 cycles
    eng_delay = 6; eng_rdata = 8'h5A;
    push(16'h4000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A);
    HOST_VALID = 1'b0;
    chk("issue_latency_pre", 32'(BUS_EN), 0);
    @(negedge CLK);
    chk("issue_latency", 32'(BUS_EN), 1);
    count_en(n);
    chk("read_en_cycles", 32'(n), 6);
    chk("read_rsp_valid", 32'(RSP_VALID), 1);
    chk("read_rsp_data", 32'(RSP_DATA), 32'h5A);
    chk("read_err", 32'(ERR), 0);
    repeat (3) @(negedge CLK);

    // back-pressure with five writes
    eng_delay = 10;
    for (int i = 0; i < 5; i++)
      push(16'h8000 + 16'(i), 8'h10 + 8'(i), 1'b1, i[0], i[1], 8'h00);
    chk("bp_level_full", 32'(LEVEL), 4);
    chk("bp_host_ready", 32'(HOST_READY), 0);
    HOST_ADDR = 16'hDEAD; HOST_WDATA = 8'hEE;
    repeat (2) @(negedge CLK);
    HOST_VALID = 1'b0;
    chk("bp_level_hold", 32'(LEVEL), 4);
    n = 0;
    while ((LEVEL != 0 || BUS_EN) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n == 200) fail("bp_drain");
    repeat (3) @(negedge CLK);
    chk("bp_issued_count", 32'(bus_rises), 6);

    // timeout on a read
    eng_delay = 0;
    push(16'h0123, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
    HOST_VALID = 1'b0;
    wait_en(1'b1, "to_issue");
    count_en(n);
    chk("to_en_cycles", 32'(n), 16);
    chk("to_err_set", 32'(ERR), 1);
    chk("to_rsp_valid", 32'(RSP_VALID), 1);
    chk("to_rsp_data", 32'(RSP_DATA), 32'hFF);
    repeat (2) @(negedge CLK);
    chk("to_err_sticky", 32'(ERR), 1);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    chk("to_err_clear", 32'(ERR), 0);

    // DONE on the expiry cycle
    eng_delay = 16; eng_rdata = 8'hC3;
    push(16'h7FFF, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3);
    HOST_VALID = 1'b0;
    wait_en(1'b1, "race_issue");
    count_en(n);
    chk("race_en_cycles", 32'(n), 16);
    chk("race_err", 32'(ERR), 0);
    chk("race_rsp_data", 32'(RSP_DATA), 32'hC3);
    repeat (3) @(negedge CLK);

    // response stall with two queued reads
    RSP_READY = 1'b0; eng_delay = 2; eng_rdata = 8'h3C;
    push(16'h2000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C);
    push(16'h2001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C);
    HOST_VALID = 1'b0;
    wait_en(1'b1, "stall_first_issue");
    wait_en(1'b0, "stall_first_done");
    n = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BUS_EN) n++;
    end
    chk("stall_no_issue", 32'(n), 0);
    chk("stall_rsp_held", 32'(RSP_VALID), 1);
    chk("stall_level", 32'(LEVEL), 1);
    RSP_READY = 1'b1;
    @(negedge CLK);
    chk("stall_resp_edge", 32'(BUS_EN), 0);
    @(negedge CLK);
    chk("stall_gap_edge", 32'(BUS_EN), 0);
    @(negedge CLK);
    chk("stall_second_issue", 32'(BUS_EN), 1);
    wait_en(1'b0, "stall_second_done");
    repeat (3) @(negedge CLK);

    // reset in ISSUE with three queued commands and ERR set
    eng_delay = 0;
    for (int i = 0; i < 4; i++)
      push(16'hA000 + 16'(i), 8'h20 + 8'(i), 1'b1, 1'b1, 1'b0, 8'h00);
    HOST_VALID = 1'b0;
    wait_en(1'b0, "rst_first_timeout");
    chk("rst_pre_err", 32'(ERR), 1);
    wait_en(1'b1, "rst_second_issue");
    push(16'hA004, 8'h24, 1'b1, 1'b1, 1'b0, 8'h00);
    HOST_VALID = 1'b0;
    chk("rst_pre_level", 32'(LEVEL), 3);
    chk("rst_pre_bus_en", 32'(BUS_EN), 1);
    #3 RST = 1'b0;
    #1;
    chk("rst_mid_bus_en", 32'(BUS_EN), 0);
    chk("rst_mid_bus_addr", 32'(BUS_ADDR), 0);
    chk("rst_mid_bus_wdata", 32'(BUS_WDATA), 0);
    chk("rst_mid_level", 32'(LEVEL), 0);
    chk("rst_mid_host_ready", 32'(HOST_READY), 1);
    chk("rst_mid_err", 32'(ERR), 0);
    chk("rst_mid_rsp_valid", 32'(RSP_VALID), 0);
    exp_bus.delete();
    @(negedge CLK);
    RST = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      if (BUS_EN) n++;
    end
    chk("rst_post_no_issue", 32'(n), 0);
    chk("rst_post_level", 32'(LEVEL), 0);
    chk("end_bus_queue", 32'(exp_bus.size()), 0);
    chk("end_rsp_queue", 32'(exp_rsp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
